i2c_config_sequencer: RTL
=========================

Name: i2c_config_sequencer

Overview:
- Walks a register-initialisation table and writes it through the board's I2C byte engine, e.g. audio codec setup before SPC700 audio output is enabled.
- Issues one-cycle command pulses to the byte engine and waits on its ready/busy/error status.
- Retries entries that are NACKed and reports done or failure to system control.
- Runs on the same (slow) clock as the I2C byte engine.

Parameters:
- DEV_ADDR, 7'h1A: 7-bit I2C target address. Write bit 0 is appended.
- NUM_ENTRIES, 11: number of table entries, valid range 1..2^IDX_W.
- IDX_W, 4: width of the table index.
- MAX_RETRY, 3: retries allowed per entry after the first attempt.
- POWERUP_CYCLES, 1024: idle cycles after reset before the first transaction.

Ports:
- clock  in  1  shared with the I2C byte engine
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; (re)runs the whole table; honoured only in IDLE, DONE or FAIL
- tbl_index  out  IDX_W  table address; tbl_data must be valid in the same cycle (combinational ROM)
- tbl_data  in  16  entry: [15:8] first byte, [7:0] second byte
- cfg_busy  out  1  high from accepted start until DONE/FAIL
- cfg_done  out  1  level; all entries ACKed
- cfg_fail  out  1  level; an entry exhausted its retries
- fail_index  out  IDX_W  index of the failing entry
- m_start_transaction, m_end_transaction, m_start_write, m_start_read  out  1 each  one-cycle command pulses to the engine; m_start_read is constant 0
- m_data_out  out  8  byte to write; held stable from the write pulse until the wait completes
- m_ready  in  1  engine idle/ready
- m_busy  in  1  engine busy
- m_error  in  1  engine NACK flag, sticky until the transaction ends

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=POWERUP, counter=0, index=0, retry=0.
  - All command pulses 0, m_data_out=0, cfg_busy=0, cfg_done=0, cfg_fail=0, fail_index=0.
  - Reset mid-sequence abandons the transfer with no STOP issued. The engine's own next start_transaction recovers the bus.
- POWERUP: count POWERUP_CYCLES, then go to IDLE. A start pulse arriving here is latched and acted on when IDLE is reached.
- IDLE/DONE/FAIL, on start:
  - Clear cfg_done, cfg_fail and fail_index; set index=0, retry=0, cfg_busy=1.
  - Go to START.
- Command issue rule:
  - Each command state drives exactly one pulse for one cycle, then enters WAIT.
  - WAIT ignores its first cycle, because the engine's ready is stale then.
  - WAIT completes on the first later cycle with m_ready=1 and m_busy=0, then moves to the successor state.
  - There is no timeout.
- Sequence per entry:
  - START: pulse m_start_transaction.
  - DEV: m_data_out={DEV_ADDR,1'b0}, pulse m_start_write.
  - CHK: if m_error, go to ERR_STOP; else continue.
  - HI: m_data_out=tbl_data[15:8], pulse m_start_write.
  - CHK.
  - LO: m_data_out=tbl_data[7:0], pulse m_start_write.
  - CHK.
  - STOP: pulse m_end_transaction, then WAIT.
  - NEXT: retry=0; if index==NUM_ENTRIES-1 go to DONE, else index+=1 and go to START.
- m_error is sampled only in CHK, i.e. the cycle after WAIT completes.
- ERR_STOP:
  - Pulse m_end_transaction, WAIT. This clears the engine's error.
  - Then, if retry==MAX_RETRY: fail_index=index and go to FAIL.
  - Else retry+=1 and restart the same entry at START.
- tbl_index=index at all times. Index and retry counters never wrap; the bounds are checked before incrementing.
- DONE: cfg_done=1, cfg_busy=0. FAIL: cfg_fail=1, cfg_busy=0.
- cfg_done and cfg_fail are never high together.
- At most one m_* pulse is high in any cycle.

Test Plan:
- Model engine always ACKs, NUM_ENTRIES=2, tbl={16'h1E00, 16'h0C10}, start pulse after powerup -> bytes 34,1E,00 then 34,0C,10, each group bracketed by start/end transaction; cfg_done=1, cfg_busy=0, 3 write pulses per entry.
- Model NACKs the device byte of entry 0 exactly twice -> two ERR_STOP end pulses, third attempt succeeds, cfg_done=1, retry resets for entry 1.
- Model always NACKs entry 1, MAX_RETRY=3 -> entry 1 attempted 4 times, cfg_fail=1, fail_index=1, cfg_done=0, last command is m_end_transaction.
- Start pulsed during POWERUP and again while cfg_busy=1 -> the first is honoured once powerup ends, the second is ignored; exactly one table pass occurs.
- reset_n=0 for one cycle during the HI write -> next cycle all outputs are at reset values and the state is POWERUP; a later start reruns from index 0.
- Model holds m_busy=1 for 50 cycles after each pulse -> no new pulse until m_ready=1 and m_busy=0; m_data_out stays stable throughout each wait.

Source files
------------

// File: rtl/i2c_config_sequencer.sv
// rtl/i2c_config_sequencer.sv - walks a register table and writes each entry over the I2C byte engine
// Each entry is one transaction: device address, high byte, low byte; NACKed entries are retried.
module i2c_config_sequencer #(
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         NUM_ENTRIES    = 11,
    parameter int         IDX_W          = 4,
    parameter int         MAX_RETRY      = 3,
    parameter int         POWERUP_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    output logic [IDX_W-1:0] tbl_index,
    input  logic [15:0]      tbl_data,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_fail,
    output logic [IDX_W-1:0] fail_index,
    output logic             m_start_transaction,
    output logic             m_end_transaction,
    output logic             m_start_write,
    output logic             m_start_read,
    output logic [7:0]       m_data_out,
    input  logic             m_ready,
    input  logic             m_busy,
    input  logic             m_error
);

    localparam int CNT_W = $clog2(POWERUP_CYCLES + 1);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_POWERUP, S_IDLE, S_START, S_DEV, S_HI, S_LO, S_STOP,
        S_ERR_STOP, S_RETRY, S_WAIT, S_CHK, S_NEXT, S_DONE, S_FAIL
    } state_t;

    state_t            r_state, r_wait_next, r_chk_next;
    state_t            w_next, w_wait_next, w_chk_next;
    logic              r_wait_first;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_index;
    logic [RTY_W-1:0]  r_retry;
    logic [7:0]        r_data;
    logic              r_busy, r_done, r_fail, r_start_pend;
    logic [IDX_W-1:0]  r_fail_index;
    logic              w_accept;

    assign tbl_index    = r_index;
    assign m_data_out   = r_data;
    assign cfg_busy     = r_busy;
    assign cfg_done     = r_done;
    assign cfg_fail     = r_fail;
    assign fail_index   = r_fail_index;
    assign m_start_read = 1'b0;

    always_comb begin
        w_next              = r_state;
        w_wait_next         = r_wait_next;
        w_chk_next          = r_chk_next;
        w_accept            = 1'b0;
        m_start_transaction = 1'b0;
        m_end_transaction   = 1'b0;
        m_start_write       = 1'b0;
        case (r_state)
            S_POWERUP: if (r_cnt == CNT_LAST) w_next = S_IDLE;
            S_IDLE, S_DONE, S_FAIL: begin
                w_accept = start | r_start_pend;
                if (w_accept) w_next = S_START;
            end
            S_START: begin
                m_start_transaction = 1'b1;
                w_next      = S_WAIT;
                w_wait_next = S_DEV;
            end
            S_DEV, S_HI, S_LO: begin
                m_start_write = 1'b1;
                w_next        = S_WAIT;
                w_wait_next   = S_CHK;
                w_chk_next    = (r_state == S_DEV) ? S_HI :
                                (r_state == S_HI)  ? S_LO : S_STOP;
            end
            S_CHK: w_next = m_error ? S_ERR_STOP : r_chk_next;
            S_STOP: begin
                m_end_transaction = 1'b1;
                w_next      = S_WAIT;
                w_wait_next = S_NEXT;
            end
            S_ERR_STOP: begin
                m_end_transaction = 1'b1;
                w_next      = S_WAIT;
                w_wait_next = S_RETRY;
            end
            S_RETRY: w_next = (r_retry == RTY_LAST) ? S_FAIL : S_START;
            S_NEXT:  w_next = (r_index == IDX_LAST) ? S_DONE : S_START;
            // The engine's ready still reflects the previous command on the first WAIT cycle.
            S_WAIT: if (!r_wait_first && m_ready && !m_busy) w_next = r_wait_next;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= S_POWERUP;
            r_wait_next  <= S_IDLE;
            r_chk_next   <= S_IDLE;
            r_wait_first <= 1'b0;
            r_cnt        <= '0;
            r_index      <= '0;
            r_retry      <= '0;
            r_data       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_index <= '0;
            r_start_pend <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_wait_next  <= w_wait_next;
            r_chk_next   <= w_chk_next;
            r_wait_first <= (w_next == S_WAIT) && (r_state != S_WAIT);
            if (r_state == S_POWERUP) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (start) r_start_pend <= 1'b1;
            end
            if (w_accept) begin
                r_done       <= 1'b0;
                r_fail       <= 1'b0;
                r_fail_index <= '0;
                r_index      <= '0;
                r_retry      <= '0;
                r_busy       <= 1'b1;
                r_start_pend <= 1'b0;
            end
            case (w_next)
                S_DEV:   r_data <= {DEV_ADDR, 1'b0};
                S_HI:    r_data <= tbl_data[15:8];
                S_LO:    r_data <= tbl_data[7:0];
                default: ;
            endcase
            if (r_state == S_NEXT) begin
                r_retry <= '0;
                if (r_index == IDX_LAST) begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end else begin
                    r_index <= r_index + IDX_W'(1);
                end
            end
            if (r_state == S_RETRY) begin
                if (r_retry == RTY_LAST) begin
                    r_fail_index <= r_index;
                    r_fail       <= 1'b1;
                    r_busy       <= 1'b0;
                end else begin
                    r_retry <= r_retry + RTY_W'(1);
                end
            end
        end
    end

endmodule
